pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Registered, parametrised program-counter unit for the 16-bit pipeline core; generalises the combinational PC control block.
- Holds the fetch PC and evaluates the 3-bit branch condition against the ALU flags.
- Selects the next PC from three sources: sequential PC+2, PC-relative immediate branch (B), or register-indirect branch (BR).
- Implements stall and a RUN/HALTED state machine driven by the HLT instruction.

Parameters:
- ADDR_W, 16, PC / address width in bits.
- IMM_W, 9, width of the signed branch offset field, in instruction words.
- RESET_PC, 0, PC value loaded on reset (ADDR_W bits, must be even).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold PC; ignore branch and halt inputs this cycle.
- br_en  in  1  instruction at current pc is a branch.
- br_reg  in  1  1 = BR (register target); 0 = B (immediate target).
- cond  in  3  branch condition code.
- imm  in  IMM_W  signed word offset, used for B.
- flags  in  3  {Z, V, N}: flags[2]=Z, flags[1]=V, flags[0]=N.
- reg_target  in  ADDR_W  target address, used for BR.
- halt_in  in  1  instruction at current pc is HLT.
- pc  out  ADDR_W  current fetch address (registered).
- pc_plus2  out  ADDR_W  pc+2, combinational, modulo 2^ADDR_W.
- taken  out  1  combinational; branch will be taken at next edge.
- halted  out  1  registered; 1 in HALTED state.
- br_cnt  out  16  branch statistics counter (see Optional Feature).
- tkn_cnt  out  16  taken-branch statistics counter (see Optional Feature).

Behaviour:
- Reset (clk edge with rst=1):
  - pc=RESET_PC, state=RUN, halted=0, counters=0.
  - Reset overrides every other input, including in HALTED state and mid-stall.
- Condition evaluation (combinational), cond_true:
  - 000 NE: Z==0.
  - 001 EQ: Z==1.
  - 010 GT: Z==0 && N==0.
  - 011 LT: N==1.
  - 100 GE: Z==1 || (Z==0 && N==0).
  - 101 LE: N==1 || Z==1.
  - 110 OV: V==1.
  - 111 UNC: always true.
- taken = state==RUN && !stall && !halt_in && br_en && cond_true.
- Branch targets, all arithmetic modulo 2^ADDR_W:
  - B: pc_plus2 + (sign_extend(imm) << 1).
  - BR: {reg_target[ADDR_W-1:1], 1'b0} (bit 0 is forced to 0).
- RUN state, next-edge priority (highest first):
  1. stall=1 -> pc holds; halt_in, br_en ignored; counters unchanged.
  2. halt_in=1 -> pc holds at the HLT address; state->HALTED; halted=1 from next cycle; br_en ignored.
  3. taken=1 -> pc=target.
  4. otherwise -> pc=pc_plus2. This includes br_en with cond false.
- HALTED state:
  - pc frozen; all inputs except rst ignored; taken=0.
  - Only reset exits HALTED.
- Latency:
  - pc changes one cycle after the decision inputs are sampled.
  - taken and pc_plus2 are valid in the same cycle as their inputs.
- Wrap-around: pc=2^ADDR_W-2 with sequential advance gives pc=0. Branch targets wrap the same way; no error is flagged.
- Inputs are sampled only at the rising edge; no internal state other than pc, state and counters.

Optional Feature:
- Macro: PC_UNIT_STATS_EN.
- Defined:
  - br_cnt increments on each edge where state==RUN, !stall, !halt_in, br_en.
  - tkn_cnt increments on each edge where taken=1.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: br_cnt and tkn_cnt are tied to 0; no counter flops are synthesised; ports remain present.

Test Plan:
- Reset then 3 idle cycles (br_en=0, halt_in=0) -> pc = 0x0000, 0x0002, 0x0004, 0x0006; halted=0.
- pc=0x0002, br_en=1, br_reg=0, cond=111, imm=9'h003 -> taken=1; next pc=0x000A. Then imm=9'h1FF (−1) at pc=0x000A -> next pc=0x000A (pc+2−2).
- Full cond sweep at pc=0x0010, imm=9'h004, for every cond × flags combination -> next pc is 0x001A when cond_true, else 0x0012; tkn_cnt matches the number of taken cases under PC_UNIT_STATS_EN.
- BR: br_reg=1, cond=111, reg_target=0x1235 -> next pc=0x1234. Wrap check: pc=0xFFFE, no branch -> next pc=0x0000.
- Stall: stall=1 with br_en=1, cond=111, halt_in=1 at pc=0x0020 -> pc stays 0x0020, taken=0, halted stays 0, counters unchanged. Release stall with halt_in=1 -> halted=1 next cycle; pc stays 0x0020 for 5 further cycles despite br_en=1.
- While HALTED, assert rst for one edge -> pc=0x0000, halted=0, br_cnt=tkn_cnt=0. Next idle edge -> pc=0x0002.

Source files
------------

// File: rtl/pc_unit.sv
// ============================================================================
// Module   : pc_unit
// Brief    : Registered program counter with branch-condition evaluation,
//            stall and HLT-driven RUN/HALTED control. Define PC_UNIT_STATS_EN
//            to build the saturating branch statistics counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pc_unit #(
    parameter int                ADDR_W   = 16,
    parameter int                IMM_W    = 9,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              br_en,
    input  logic              br_reg,
    input  logic [2:0]        cond,
    input  logic [IMM_W-1:0]  imm,
    input  logic [2:0]        flags,
    input  logic [ADDR_W-1:0] reg_target,
    input  logic              halt_in,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus2,
    output logic              taken,
    output logic              halted,
    output logic [15:0]       br_cnt,
    output logic [15:0]       tkn_cnt
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_imm_ext;
    logic [ADDR_W-1:0] w_b_target;
    logic [ADDR_W-1:0] w_br_target;
    logic              w_z;
    logic              w_v;
    logic              w_n;
    logic              w_cond_true;
    logic              w_br_valid;

    assign {w_z, w_v, w_n} = flags;

    always_comb begin
        w_cond_true = 1'b0;
        case (cond)
            3'b000:  w_cond_true = !w_z;
            3'b001:  w_cond_true = w_z;
            3'b010:  w_cond_true = !w_z && !w_n;
            3'b011:  w_cond_true = w_n;
            3'b100:  w_cond_true = w_z || (!w_z && !w_n);
            3'b101:  w_cond_true = w_n || w_z;
            3'b110:  w_cond_true = w_v;
            default: w_cond_true = 1'b1;
        endcase
    end

    // A branch only counts as "seen" when the pipeline actually advances past it.
    assign w_br_valid = (r_state == ST_RUN) && !stall && !halt_in && br_en;
    assign taken      = w_br_valid && w_cond_true;

    assign pc_plus2    = r_pc + ADDR_W'(2);
    assign w_imm_ext   = ADDR_W'($signed(imm));
    assign w_b_target  = pc_plus2 + (w_imm_ext << 1);
    assign w_br_target = reg_target & ~ADDR_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        if (r_state == ST_RUN && !stall) begin
            if (halt_in) begin
                w_state_nxt = ST_HALTED;
            end else if (taken) begin
                w_pc_nxt = br_reg ? w_br_target : w_b_target;
            end else begin
                w_pc_nxt = pc_plus2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    assign pc     = r_pc;
    assign halted = (r_state == ST_HALTED);

`ifdef PC_UNIT_STATS_EN
    logic [15:0] r_br_cnt;
    logic [15:0] r_tkn_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_br_cnt  <= '0;
            r_tkn_cnt <= '0;
        end else begin
            if (w_br_valid && r_br_cnt != 16'hFFFF) begin
                r_br_cnt <= r_br_cnt + 16'd1;
            end
            if (taken && r_tkn_cnt != 16'hFFFF) begin
                r_tkn_cnt <= r_tkn_cnt + 16'd1;
            end
        end
    end

    assign br_cnt  = r_br_cnt;
    assign tkn_cnt = r_tkn_cnt;
`else
    assign br_cnt  = '0;
    assign tkn_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_unit.sv
// ============================================================================
// Module   : tb_pc_unit
// Brief    : Directed self-checking bench for pc_unit (default and
//            PC_UNIT_STATS_EN builds).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pc_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        br_en;
    logic        br_reg;
    logic [2:0]  cond;
    logic [8:0]  imm;
    logic [2:0]  flags;
    logic [15:0] reg_target;
    logic        halt_in;
    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic        taken;
    logic        halted;
    logic [15:0] br_cnt;
    logic [15:0] tkn_cnt;

    int checks = 0;
    int errors = 0;

    pc_unit #(
        .ADDR_W   (16),
        .IMM_W    (9),
        .RESET_PC (16'h0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .br_en      (br_en),
        .br_reg     (br_reg),
        .cond       (cond),
        .imm        (imm),
        .flags      (flags),
        .reg_target (reg_target),
        .halt_in    (halt_in),
        .pc         (pc),
        .pc_plus2   (pc_plus2),
        .taken      (taken),
        .halted     (halted),
        .br_cnt     (br_cnt),
        .tkn_cnt    (tkn_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle;
        stall      = 1'b0;
        br_en      = 1'b0;
        br_reg     = 1'b0;
        cond       = 3'b000;
        imm        = 9'h000;
        flags      = 3'b000;
        reg_target = 16'h0000;
        halt_in    = 1'b0;
    endtask

    // Unconditional BR to the given address, then back to idle inputs.
    task automatic jump_to(input logic [15:0] addr);
        br_en      = 1'b1;
        br_reg     = 1'b1;
        cond       = 3'b111;
        reg_target = addr;
        tick();
        set_idle();
    endtask

    task automatic test_reset;
        set_idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (pc !== 16'h0000) begin
            errors++; $display("FAIL reset_pc: got %h expected %h", pc, 16'h0000);
        end
        checks++;
        if (halted !== 1'b0) begin
            errors++; $display("FAIL reset_halted: got %b expected 0", halted);
        end
        checks++;
        if (br_cnt !== 16'h0000 || tkn_cnt !== 16'h0000) begin
            errors++; $display("FAIL reset_counters: got %h/%h expected 0000/0000", br_cnt, tkn_cnt);
        end
        checks++;
        if (pc_plus2 !== 16'h0002) begin
            errors++; $display("FAIL reset_pc_plus2: got %h expected 0002", pc_plus2);
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (pc !== 16'(2 * i) || halted !== 1'b0) begin
                errors++;
                $display("FAIL idle_seq[%0d]: got pc=%h halted=%b expected pc=%h halted=0",
                         i, pc, halted, 16'(2 * i));
            end
        end
    endtask

    task automatic test_branch_imm;
        set_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (pc !== 16'h0002) begin
            errors++; $display("FAIL b_setup_pc: got %h expected 0002", pc);
        end
        br_en = 1'b1; br_reg = 1'b0; cond = 3'b111; imm = 9'h003;
        #1;
        checks++;
        if (taken !== 1'b1) begin
            errors++; $display("FAIL b_fwd_taken: got %b expected 1", taken);
        end
        tick();
        checks++;
        if (pc !== 16'h000A) begin
            errors++; $display("FAIL b_fwd_pc: got %h expected 000A", pc);
        end
        imm = 9'h1FF;
        tick();
        checks++;
        if (pc !== 16'h000A) begin
            errors++; $display("FAIL b_back_pc: got %h expected 000A", pc);
        end
        set_idle();
    endtask

    task automatic test_cond_sweep;
        // Bit f of mask[c] is the expected cond_true for flags={Z,V,N}=f.
        logic [7:0]  mask [8];
        logic [7:0]  m;
        logic        exp_t;
        logic [15:0] br0;
        logic [15:0] tk0;
        logic [15:0] exp_br;
        logic [15:0] exp_tk;
        mask = '{8'h0F, 8'hF0, 8'h05, 8'hAA, 8'hF5, 8'hFA, 8'hCC, 8'hFF};
        set_idle();
        br0 = br_cnt;
        tk0 = tkn_cnt;
        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 8; f++) begin
                jump_to(16'h0010);
                cond = 3'(c); flags = 3'(f); imm = 9'h004;
                br_en = 1'b1; br_reg = 1'b0;
                m = mask[c];
                exp_t = m[f];
                #1;
                checks++;
                if (taken !== exp_t) begin
                    errors++;
                    $display("FAIL sweep_taken c=%0d f=%0d: got %b expected %b", c, f, taken, exp_t);
                end
                tick();
                checks++;
                if (pc !== (exp_t ? 16'h001A : 16'h0012)) begin
                    errors++;
                    $display("FAIL sweep_pc c=%0d f=%0d: got %h expected %h",
                             c, f, pc, exp_t ? 16'h001A : 16'h0012);
                end
                set_idle();
            end
        end
`ifdef PC_UNIT_STATS_EN
        // 64 setup jumps plus 64 swept branches; 64 + 38 of them taken.
        exp_br = br0 + 16'd128;
        exp_tk = tk0 + 16'd102;
`else
        exp_br = 16'h0000;
        exp_tk = 16'h0000;
`endif
        checks++;
        if (br_cnt !== exp_br || tkn_cnt !== exp_tk) begin
            errors++;
            $display("FAIL sweep_counters: got %h/%h expected %h/%h", br_cnt, tkn_cnt, exp_br, exp_tk);
        end
    endtask

    task automatic test_br_wrap;
        set_idle();
        jump_to(16'h1235);
        checks++;
        if (pc !== 16'h1234) begin
            errors++; $display("FAIL br_target: got %h expected 1234", pc);
        end
        jump_to(16'hFFFF);
        checks++;
        if (pc !== 16'hFFFE || pc_plus2 !== 16'h0000) begin
            errors++; $display("FAIL br_top: got pc=%h pc_plus2=%h expected FFFE/0000", pc, pc_plus2);
        end
        tick();
        checks++;
        if (pc !== 16'h0000) begin
            errors++; $display("FAIL seq_wrap: got %h expected 0000", pc);
        end
        br_en = 1'b1; br_reg = 1'b0; cond = 3'b111; imm = 9'h1FE;
        tick();
        checks++;
        if (pc !== 16'hFFFE) begin
            errors++; $display("FAIL b_wrap: got %h expected FFFE", pc);
        end
        set_idle();
    endtask

    task automatic test_stall_halt;
        logic [15:0] br0;
        logic [15:0] tk0;
        set_idle();
        jump_to(16'h0020);
        br0 = br_cnt;
        tk0 = tkn_cnt;
        stall = 1'b1; br_en = 1'b1; cond = 3'b111; halt_in = 1'b1;
        #1;
        checks++;
        if (taken !== 1'b0) begin
            errors++; $display("FAIL stall_taken: got %b expected 0", taken);
        end
        tick();
        checks++;
        if (pc !== 16'h0020 || halted !== 1'b0) begin
            errors++; $display("FAIL stall_hold: got pc=%h halted=%b expected 0020/0", pc, halted);
        end
        stall = 1'b0;
        #1;
        checks++;
        if (taken !== 1'b0) begin
            errors++; $display("FAIL halt_taken: got %b expected 0", taken);
        end
        tick();
        checks++;
        if (pc !== 16'h0020 || halted !== 1'b1) begin
            errors++; $display("FAIL halt_enter: got pc=%h halted=%b expected 0020/1", pc, halted);
        end
        halt_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (taken !== 1'b0) begin
                errors++; $display("FAIL halted_taken[%0d]: got %b expected 0", i, taken);
            end
            tick();
            checks++;
            if (pc !== 16'h0020 || halted !== 1'b1) begin
                errors++;
                $display("FAIL halted_hold[%0d]: got pc=%h halted=%b expected 0020/1", i, pc, halted);
            end
        end
        checks++;
        if (br_cnt !== br0 || tkn_cnt !== tk0) begin
            errors++;
            $display("FAIL stall_halt_counters: got %h/%h expected %h/%h", br_cnt, tkn_cnt, br0, tk0);
        end
    endtask

    task automatic test_reset_from_halt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_idle();
        checks++;
        if (pc !== 16'h0000 || halted !== 1'b0) begin
            errors++; $display("FAIL halt_reset: got pc=%h halted=%b expected 0000/0", pc, halted);
        end
        checks++;
        if (br_cnt !== 16'h0000 || tkn_cnt !== 16'h0000) begin
            errors++; $display("FAIL halt_reset_counters: got %h/%h expected 0000/0000", br_cnt, tkn_cnt);
        end
        tick();
        checks++;
        if (pc !== 16'h0002) begin
            errors++; $display("FAIL post_reset_seq: got %h expected 0002", pc);
        end
    endtask

    initial begin
        rst = 1'b1;
        set_idle();
        test_reset();
        test_branch_imm();
        test_cond_sweep();
        test_br_wrap();
        test_stall_halt();
        test_reset_from_halt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
